// File: rtl/mvm_out_stream_if.sv
// Bundle for the result-capture side (s_*) and the row stream side (m_*)
// of the mvm_out_stream block.
interface mvm_out_stream_if #(
  parameter int R   = 8,
  parameter int W_Y = 19,
  parameter int W_B = 16,
  parameter int W_O = 8
);
  localparam int W_IDX = (R > 1) ? $clog2(R) : 1;

  logic                        s_valid;
  logic                        s_ready;
  logic [R-1:0][W_Y-1:0]       s_y;
  logic [R-1:0][W_B-1:0]       bias;
  logic                        relu_en;
  logic                        m_valid;
  logic                        m_ready;
  logic signed [W_O-1:0]       m_data;
  logic [W_IDX-1:0]            m_idx;
  logic                        m_last;

  // Environment side: feeds result vectors and accepts rows.
  modport master (
    output s_valid, s_y, bias, relu_en, m_ready,
    input  s_ready, m_valid, m_data, m_idx, m_last
  );

  // Block side.
  modport slave (
    input  s_valid, s_y, bias, relu_en, m_ready,
    output s_ready, m_valid, m_data, m_idx, m_last
  );
endinterface

// File: rtl/mvm_out_stream.sv
// Captures one R-row accumulated result vector, applies bias / ReLU /
// rounding requantize with saturation, and streams rows one per cycle.
// s_ready doubles as the upstream multiplier pipeline-advance enable.
module mvm_out_stream #(
  parameter int R     = 8,
  parameter int W_Y   = 19,
  parameter int W_B   = 16,
  parameter int W_O   = 8,
  parameter int SHIFT = 8
) (
  input logic           clk,
  input logic           rst,
  mvm_out_stream_if.slave bus
);
  localparam int W_IDX = (R > 1) ? $clog2(R) : 1;
  localparam int W_S   = ((W_Y > W_B) ? W_Y : W_B) + 2;
  // One extra bit so the rounding add cannot wrap.
  localparam int W_T   = W_S + 1;
  localparam logic [W_IDX-1:0] LAST = W_IDX'(R - 1);
  localparam logic signed [W_T-1:0] C_MAX = {{(W_T-W_O+1){1'b0}}, {(W_O-1){1'b1}}};
  localparam logic signed [W_T-1:0] C_MIN = {{(W_T-W_O+1){1'b1}}, {(W_O-1){1'b0}}};

  typedef enum logic {IDLE, SEND} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [W_IDX-1:0]      r_cnt;
  logic [R-1:0][W_Y-1:0] r_y;
  logic [R-1:0][W_B-1:0] r_bias;
  logic                  r_relu;

  logic                  w_last;
  logic                  w_mvalid;
  logic                  w_hs;
  logic                  w_sready;
  logic                  w_cap;

  logic signed [W_Y-1:0] w_yrow;
  logic signed [W_B-1:0] w_brow;
  logic signed [W_S-1:0] w_sum;
  logic signed [W_S-1:0] w_relu;
  logic signed [W_T-1:0] w_ext;
  logic signed [W_T-1:0] w_t;
  logic signed [W_O-1:0] w_data;

  assign w_last   = (r_cnt == LAST);
  assign w_mvalid = (r_state == SEND);
  assign w_hs     = w_mvalid && bus.m_ready;
  assign w_sready = !rst && ((r_state == IDLE) || (w_hs && w_last));
  assign w_cap    = bus.s_valid && w_sready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: a capture during the last-row handshake keeps us in SEND.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_cap) w_state_nxt = SEND;
      SEND: if (w_hs && w_last) w_state_nxt = w_cap ? SEND : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Row counter: restarts on capture, advances on each row handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_cnt <= '0;
    else if (w_cap)         r_cnt <= '0;
    else if (w_hs)          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
  end

  // Capture registers: result vector, bias and relu latched together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y    <= '0;
      r_bias <= '0;
      r_relu <= 1'b0;
    end else if (w_cap) begin
      r_y    <= bus.s_y;
      r_bias <= bus.bias;
      r_relu <= bus.relu_en;
    end
  end

  assign w_yrow = r_y[r_cnt];
  assign w_brow = r_bias[r_cnt];
  assign w_sum  = {{(W_S-W_Y){w_yrow[W_Y-1]}}, w_yrow}
                + {{(W_S-W_B){w_brow[W_B-1]}}, w_brow};
  assign w_relu = (r_relu && w_sum[W_S-1]) ? '0 : w_sum;
  assign w_ext  = {w_relu[W_S-1], w_relu};

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [W_T-1:0] RND = {{(W_T-1){1'b0}}, 1'b1} << (SHIFT - 1);
      assign w_t = (w_ext + RND) >>> SHIFT;
    end else begin : g_noround
      assign w_t = w_ext;
    end
  endgenerate

  // Saturate the requantized row to the signed output range.
  always_comb begin
    w_data = w_t[W_O-1:0];
    if (w_t > C_MAX)      w_data = C_MAX[W_O-1:0];
    else if (w_t < C_MIN) w_data = C_MIN[W_O-1:0];
  end

  assign bus.s_ready = w_sready;
  assign bus.m_valid = w_mvalid;
  assign bus.m_data  = w_data;
  assign bus.m_idx   = r_cnt;
  assign bus.m_last  = w_mvalid && w_last;
endmodule
